pipe_generator: RTL and testbench

PIPE_GENERATOR -- requirements
Module: pipe_generator

---
 rtl/pipe_generator.sv | 123 ++++++++++++
 tb/tb_pipe_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_generator.sv
// Pipe scroller: three pipe slots that march left one pixel per tick
// and respawn at the right edge with an LFSR-chosen gap height.
module pipe_generator #(
  parameter int          TICK_DIV = 250000,
  parameter int          X_START  = 480,
  parameter int          SPACING  = 240,
  parameter int          HALF_W   = 40,
  parameter int          GAP      = 160,
  parameter int          Y_MIN    = 60,
  parameter int          Y_INIT   = 200,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        game_over,
  output logic [11:0] pippos0_x1,
  output logic [11:0] pippos0_x2,
  output logic [11:0] pippos0_y1,
  output logic [11:0] pippos0_y2,
  output logic [11:0] pippos1_x1,
  output logic [11:0] pippos1_x2,
  output logic [11:0] pippos1_y1,
  output logic [11:0] pippos1_y2,
  output logic [11:0] pippos2_x1,
  output logic [11:0] pippos2_x2,
  output logic [11:0] pippos2_y1,
  output logic [11:0] pippos2_y2,
  output logic        running,
  output logic [2:0]  spawn
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_t;

  localparam int          CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [11:0] X_WRAP  = 12'(3 * SPACING);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
  logic          fb;
  logic          step;
  logic [11:0]   x1 [3];
  logic [11:0]   y1 [3];
  logic [7:0]    r  [3];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // game_over beats start; FROZEN only exits through reset
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (game_over)  state_nx = FROZEN;
        else if (start) state_nx = RUN;
      end
      RUN: begin
        if (game_over) state_nx = FROZEN;
      end
      FROZEN:  state_nx = FROZEN;
      default: state_nx = IDLE;
    endcase
  end

  assign step = (state == RUN) && (cnt == CNT_MAX) && !game_over;
  assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign r[0] = lfsr[7:0];
  assign r[1] = lfsr[11:4];
  assign r[2] = lfsr[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      lfsr    <= SEED;
      running <= 1'b0;
      spawn   <= '0;
      for (int k = 0; k < 3; k++) begin
        x1[k] <= 12'(X_START + k * SPACING);
        y1[k] <= 12'(Y_INIT);
      end
    end else begin
      lfsr    <= {lfsr[14:0], fb};
      running <= (state_nx == RUN);
      spawn   <= '0;
      if (state == RUN)
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      for (int k = 0; k < 3; k++) begin
        if (step) begin
          if (x1[k] == 12'd0) begin
            x1[k]    <= X_WRAP;
            y1[k]    <= 12'(Y_MIN) + {4'b0, r[k]};
            spawn[k] <= 1'b1;
          end else begin
            x1[k] <= x1[k] - 12'd1;
          end
        end
      end
    end
  end

  assign pippos0_x1 = x1[0];
  assign pippos1_x1 = x1[1];
  assign pippos2_x1 = x1[2];
  assign pippos0_y1 = y1[0];
  assign pippos1_y1 = y1[1];
  assign pippos2_y1 = y1[2];
  assign pippos0_x2 = x1[0] + 12'(HALF_W);
  assign pippos1_x2 = x1[1] + 12'(HALF_W);
  assign pippos2_x2 = x1[2] + 12'(HALF_W);
  assign pippos0_y2 = y1[0] + 12'(GAP);
  assign pippos1_y2 = y1[1] + 12'(GAP);
  assign pippos2_y2 = y1[2] + 12'(GAP);

endmodule

// File: tb/tb_pipe_generator.sv
// Bench for pipe_generator: directed phases plus random run/crash/reset
// traffic, all checked each cycle against a behavioural model.
module tb_pipe_generator;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic [11:0] p0x1, p0x2, p0y1, p0y2;
  logic [11:0] p1x1, p1x2, p1y1, p1y2;
  logic [11:0] p2x1, p2x2, p2y1, p2y2;
  logic        running;
  logic [2:0]  spawn;

  always #5 clk = ~clk;

  pipe_generator #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .game_over(game_over),
    .pippos0_x1(p0x1), .pippos0_x2(p0x2),
    .pippos0_y1(p0y1), .pippos0_y2(p0y2),
    .pippos1_x1(p1x1), .pippos1_x2(p1x2),
    .pippos1_y1(p1y1), .pippos1_y2(p1y2),
    .pippos2_x1(p2x1), .pippos2_x2(p2x2),
    .pippos2_y1(p2y1), .pippos2_y2(p2y2),
    .running(running), .spawn(spawn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 run, 2 frozen
  int          m_state;
  int          m_cnt;
  logic [15:0] m_lfsr;
  int          m_x [3];
  int          m_y [3];
  logic [2:0]  m_spawn;

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit stp;
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_lfsr  = 16'hACE1;
      m_spawn = 3'b000;
      for (int k = 0; k < 3; k++) begin
        m_x[k] = 480 + 240 * k;
        m_y[k] = 200;
      end
    end else begin
      stp = (m_state == 1) && (m_cnt == TD - 1) && !game_over;
      m_spawn = 3'b000;
      if (stp) begin
        for (int k = 0; k < 3; k++) begin
          if (m_x[k] == 0) begin
            m_x[k] = 720;
            m_y[k] = 60 + int'((m_lfsr >> (4 * k)) & 16'h00FF);
            m_spawn[k] = 1'b1;
          end else begin
            m_x[k] = m_x[k] - 1;
          end
        end
      end
      if (m_state == 1) m_cnt = (m_cnt + 1) % TD;
      if (m_state != 2 && game_over) m_state = 2;
      else if (m_state == 0 && start) m_state = 1;
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic compare_all();
    chk("x1_0", int'(p0x1), m_x[0]);
    chk("x1_1", int'(p1x1), m_x[1]);
    chk("x1_2", int'(p2x1), m_x[2]);
    chk("x2_0", int'(p0x2), m_x[0] + 40);
    chk("x2_1", int'(p1x2), m_x[1] + 40);
    chk("x2_2", int'(p2x2), m_x[2] + 40);
    chk("y1_0", int'(p0y1), m_y[0]);
    chk("y1_1", int'(p1y1), m_y[1]);
    chk("y1_2", int'(p2y1), m_y[2]);
    chk("y2_0", int'(p0y2), m_y[0] + 160);
    chk("y2_1", int'(p1y2), m_y[1] + 160);
    chk("y2_2", int'(p2y2), m_y[2] + 160);
    chk("spawn", int'(spawn), int'(m_spawn));
    chk("running", int'(running), int'(m_state == 1));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int          sx;
    bit          found;
    logic [15:0] pre;

    // reset and idle
    repeat (2) cyc();
    rst = 1'b0;
    repeat (20) cyc();
    chk("idle_x1_0", int'(p0x1), 480);
    chk("idle_x1_1", int'(p1x1), 720);
    chk("idle_x1_2", int'(p2x1), 960);
    chk("idle_x2_2", int'(p2x2), 1000);
    chk("idle_y1_0", int'(p0y1), 200);
    chk("idle_y2_0", int'(p0y2), 360);
    chk("idle_run", int'(running), 0);

    // scroll
    start = 1'b1;
    cyc();
    chk("run_up", int'(running), 1);
    repeat (3) cyc();
    chk("pre_step", int'(p0x1), 480);
    cyc();
    chk("first_step", int'(p0x1), 479);
    chk("first_step_x2", int'(p0x2), 519);
    repeat (4) cyc();
    chk("second_step", int'(p0x1), 478);

    // wrap of slot 0
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      pre = m_lfsr;
      cyc();
      if (spawn !== 3'b000) found = 1'b1;
    end
    chk("wrap_seen", int'(found), 1);
    chk("wrap_spawn", int'(spawn), 1);
    chk("wrap_x1", int'(p0x1), 720);
    chk("wrap_y1", int'(p0y1), 60 + int'(pre[7:0]));
    chk("wrap_y2", int'(p0y2), 220 + int'(pre[7:0]));
    chk("order_1", int'(p1x1), 239);
    chk("order_2", int'(p2x1), 479);
    cyc();
    chk("spawn_once", int'(spawn), 0);

    // let slots 1 and 2 wrap too
    repeat (2000) cyc();

    // freeze on a step cycle
    for (int i = 0; i < 8 && m_cnt != TD - 1; i++) cyc();
    chk("step_aligned", m_cnt, TD - 1);
    sx = m_x[0];
    game_over = 1'b1;
    cyc();
    chk("freeze_x", int'(p0x1), sx);
    chk("freeze_run", int'(running), 0);
    game_over = 1'b0;
    start = 1'b1;
    repeat (20) cyc();
    chk("frozen_hold", int'(p0x1), sx);

    // mid-run reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (37) cyc();
    rst = 1'b1;
    cyc();
    chk("mrst_x0", int'(p0x1), 480);
    chk("mrst_x1", int'(p1x1), 720);
    chk("mrst_x2", int'(p2x1), 960);
    chk("mrst_run", int'(running), 0);
    rst = 1'b0;

    // start and game_over together in IDLE
    start = 1'b1;
    game_over = 1'b1;
    cyc();
    chk("prio_run", int'(running), 0);
    game_over = 1'b0;
    repeat (10) cyc();
    chk("prio_hold", int'(p0x1), 480);

    // random traffic
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3000) begin
      start     = ($urandom_range(0, 9) != 0);
      game_over = ($urandom_range(0, 1999) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
